// File: rtl/fir_inverse_if.sv
// Handshake and result bundle between a requester and the fir_inverse block.
// The requester drives go/y_in; the inverse returns the recovered sample and status.
interface fir_inverse_if;
    logic        go;
    logic [15:0] y_in;
    logic [7:0]  x_out;
    logic        valid;
    logic        err;
    logic        busy;

    modport master (output go, y_in, input x_out, valid, err, busy);
    modport slave  (input go, y_in, output x_out, valid, err, busy);
endinterface

// File: rtl/fir_inverse.sv
// Sequential inverse of the 20/15/10 3-tap FIR: recovers x[k] with a 16-step restoring divider.
// Define FIR_INVERSE_CHECK_EN to flag outputs no valid 8-bit input sequence can produce.
module fir_inverse (
    input  logic         clk,
    input  logic         rst,
    fir_inverse_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] ybuf;
    logic [15:0] dvd;
    logic [15:0] q;
    logic [4:0]  rem;
    logic [3:0]  cnt;
    logic [7:0]  x1, x2;
    logic [12:0] sub;
    logic        neg;
    logic [5:0]  rem_sh;
    logic        ge;
    logic        fault;
`ifdef FIR_INVERSE_CHECK_EN
    logic        sticky_neg;
`else
    logic        unused_q;
    assign unused_q = q[15];
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        // History term 15*x1 + 10*x2 peaks at 6375; comparing it to ybuf is the sign of r.
        sub    = 13'(x1) * 13'd15 + 13'(x2) * 13'd10;
        neg    = {3'b000, sub} > ybuf;
        rem_sh = {rem, dvd[15]};
        ge     = rem_sh >= 6'd20;
`ifdef FIR_INVERSE_CHECK_EN
        fault  = sticky_neg | (rem != 5'd0) | (q[15:8] != 8'd0);
`else
        fault  = 1'b0;
`endif
        case (state)
            IDLE:    if (bus.go) state_nxt = CALC;
            CALC:    state_nxt = DIV;
            DIV:     if (cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ybuf       <= '0;
            dvd        <= '0;
            q          <= '0;
            rem        <= '0;
            cnt        <= '0;
            x1         <= '0;
            x2         <= '0;
            bus.x_out  <= '0;
            bus.valid  <= 1'b0;
`ifdef FIR_INVERSE_CHECK_EN
            sticky_neg <= 1'b0;
            bus.err    <= 1'b0;
`endif
        end else begin
            bus.valid <= 1'b0;
`ifdef FIR_INVERSE_CHECK_EN
            bus.err   <= 1'b0;
`endif
            case (state)
                IDLE: if (bus.go) ybuf <= bus.y_in;
                CALC: begin
                    cnt <= '0;
                    rem <= '0;
                    q   <= '0;
                    dvd <= neg ? 16'd0 : ybuf - {3'b000, sub};
`ifdef FIR_INVERSE_CHECK_EN
                    sticky_neg <= neg;
`endif
                end
                DIV: begin
                    rem <= ge ? 5'(rem_sh - 6'd20) : rem_sh[4:0];
                    q   <= {q[14:0], ge};
                    dvd <= {dvd[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    if (!fault) begin
                        bus.x_out <= q[7:0];
                        x2        <= x1;
                        x1        <= q[7:0];
                        bus.valid <= 1'b1;
                    end
`ifdef FIR_INVERSE_CHECK_EN
                    bus.err <= fault;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef FIR_INVERSE_CHECK_EN
    assign bus.err = 1'b0;
`endif
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_fir_inverse.sv
// Self-checking bench for fir_inverse: directed spec scenarios plus randomized samples
// checked against an arithmetic model of the inverse FIR (build-mode aware).
module tb_fir_inverse;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_x1, m_x2, m_xout;

    fir_inverse_if bus ();
    fir_inverse u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x1 = 0; m_x2 = 0; m_xout = 0;
    endtask

    // Inverse FIR from the arithmetic definition: x = (y - 15*x1 - 10*x2) / 20.
    task automatic model(input int y, output bit ok, output int x);
        int r;
        r = y - 15 * m_x1 - 10 * m_x2;
`ifdef FIR_INVERSE_CHECK_EN
        ok = (r >= 0) && (r % 20 == 0) && (r / 20 <= 255);
        x  = ok ? r / 20 : m_xout;
`else
        if (r < 0) r = 0;
        ok = 1'b1;
        x  = (r / 20) % 256;
`endif
        if (ok) begin
            m_x2 = m_x1; m_x1 = x; m_xout = x;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One accepted sample; optionally a stray go at E<go_at> or a reset at E<rst_at>.
    task automatic run_sample(input logic [15:0] y, input int go_at, input logic [15:0] y2,
                              input int rst_at);
        int lat; bit ok; int ex; bit seen;
        lat = 0;
        @(negedge clk); bus.go = 1'b1; bus.y_in = y;
        @(negedge clk); bus.go = 1'b0; bus.y_in = 16'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rst_at > 0 && k == rst_at) begin
                check("rst_busy", bus.busy, 0);
                check("rst_x_out", bus.x_out, 0);
                check("rst_valid", bus.valid, 0);
                check("rst_err", bus.err, 0);
                @(negedge clk); rst = 1'b0;
                model_reset();
                seen = 1'b0;
                repeat (24) begin
                    @(posedge clk); #1;
                    if (bus.valid || bus.err) seen = 1'b1;
                end
                check("rst_no_pulse", seen, 0);
                return;
            end
            if (bus.valid || bus.err) begin
                lat = k;
                break;
            end
            check("busy_high", bus.busy, 1);
            if (k == go_at - 1) begin @(negedge clk); bus.go = 1'b1; bus.y_in = y2; end
            if (k == go_at)     begin @(negedge clk); bus.go = 1'b0; end
            if (rst_at > 0 && k == rst_at - 1) begin @(negedge clk); rst = 1'b1; end
        end
        model(y, ok, ex);
        check("latency", lat, 18);
        check("valid", bus.valid, ok);
        check("err", bus.err, !ok);
        check("x_out", bus.x_out, ex);
        check("busy_low", bus.busy, 0);
    endtask

    initial begin
        bit seen;
        int x, y;
        rst = 1'b1; bus.go = 1'b0; bus.y_in = '0;
        model_reset();
        do_reset();
        check("reset_x_out", bus.x_out, 0);
        check("reset_valid", bus.valid, 0);
        check("reset_err", bus.err, 0);
        check("reset_busy", bus.busy, 0);

        // Round trip 10, 20, 30.
        run_sample(16'd200, 0, 16'd0, 0);
        run_sample(16'd550, 0, 16'd0, 0);
        run_sample(16'd1000, 0, 16'd0, 0);

        // Boundaries: 255 is legal, q=256 is not.
        do_reset();
        run_sample(16'd5100, 0, 16'd0, 0);
        do_reset();
        run_sample(16'd5120, 0, 16'd0, 0);

        // Remainder fault must leave history untouched.
        do_reset();
        run_sample(16'd205, 0, 16'd0, 0);
        run_sample(16'd40, 0, 16'd0, 0);

        // Negative residual.
        do_reset();
        run_sample(16'd200, 0, 16'd0, 0);
        run_sample(16'd550, 0, 16'd0, 0);
        run_sample(16'd100, 0, 16'd0, 0);
        run_sample(16'd1000, 0, 16'd0, 0);

        // go while busy is ignored; reset mid-operation aborts.
        do_reset();
        run_sample(16'd200, 5, 16'd550, 0);
        seen = 1'b0;
        repeat (22) begin
            @(posedge clk); #1;
            if (bus.valid || bus.err) seen = 1'b1;
        end
        check("ignored_go_no_pulse", seen, 0);
        run_sample(16'd400, 0, 16'd0, 10);

        // Randomized: mostly legal FIR outputs, some arbitrary words, back-to-back gaps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) y = int'($urandom_range(0, 65535));
            else                           y = 20 * x + 15 * m_x1 + 10 * m_x2;
            run_sample(16'(y), 0, 16'd0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_inverse.md
# fir_inverse

Sequential inverse of the team's 3-tap FIR (y = 20·x[k] + 15·x[k-1] + 10·x[k-2]). It sits at the output end of the FIR and receives one 16-bit filter output per `go` strobe. From each output it recovers the 8-bit input sample: x[k] = (y[k] − 15·x[k-1] − 10·x[k-2]) / 20. The division is a multi-cycle restoring divider controlled by a small FSM. Any output that a valid 8-bit input sequence cannot produce is flagged as an error.

## Interface
- No parameters. Coefficients are fixed at 20/15/10 to match the FIR.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high; clears all state.
- `go` in 1: single-cycle clean strobe; requests reconstruction of `y_in`.
- `y_in` in 16: unsigned FIR output sample; sampled on the accepting edge.
- `x_out` out 8: last successfully recovered sample.
- `valid` out 1: one-cycle pulse when `x_out` is updated.
- `err` out 1: one-cycle pulse when a sample is rejected (check build only).
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- **Reset values:** `x_out`=0, `valid`=0, `err`=0, `busy`=0; history x1=x2=0; FSM=IDLE.
- **IDLE:** if `go`=1, latch `y_in` into `ybuf` and go to CALC. Otherwise stay.
- **CALC:** compute r = ybuf − 15·x1 − 10·x2 as 18-bit signed. Nonnegative r is loaded as a 16-bit dividend, the divider is cleared, cnt=0, and the FSM goes to DIV. Negative r sets a sticky fault and loads dividend 0.
- **DIV:** 16 restoring steps by constant 20, one quotient bit per cycle, MSB first. Each step: rem = {rem, next dividend bit}; if rem ≥ 20, subtract 20 and set the quotient bit to 1. After cnt=15, go to DONE.
- **DONE:** fault = sticky_neg OR rem≠0 OR q>255.
  - No fault: `x_out`←q[7:0], x2←x1, x1←q[7:0], `valid`=1.
  - Fault: `err`=1; `x_out` and history are unchanged.
  - In both cases the FSM returns to IDLE.
- **Arithmetic widths:** 15·x1 ≤ 3825; 10·x2 ≤ 2550. The 18-bit signed intermediate cannot overflow. q is 16 bits; only q ≤ 255 is legal.
- **`go` while busy:** ignored. It is neither queued nor counted.
- **`rst` in any state:** aborts the operation. Outputs and history are at reset values on the next cycle, and no `valid` or `err` is emitted for the aborted sample.
- `valid` and `err` are never high in the same cycle.

## Timing
- Call the edge that samples `go`=1 in IDLE E0. CALC runs at E1, DIV at E2..E17, DONE at E18.
- `valid`/`err` are high during the cycle after E18. The latency from the accepting edge is 18 cycles.
- `busy` is high from the cycle after E0 through the cycle after E17, then low when `valid`/`err` is high.
- Back-to-back: `go` may be accepted on the edge where `valid` is high (the FSM is IDLE). The minimum accepted spacing is 19 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `FIR_INVERSE_CHECK_EN` defined:
  - Full fault detection as above: negative r, nonzero remainder, q > 255.
  - `err` is driven.
- Not defined:
  - `err` is tied to 0.
  - Negative r is clamped to 0, the remainder is ignored, and `x_out`=q[7:0] (truncated).
  - History updates and `valid` pulses on every accepted sample.

## Test plan
- **Round trip:** after reset, `go` with y=200, then 550, then 1000, with each strobe issued after the previous `valid`. Required: `x_out`=10, 20, 30, each with a `valid` pulse 18 cycles after its `go`.
- **Boundary:** after reset, y=5100 → `x_out`=255 with `valid`. Then after reset, y=5120 → `err` pulse (q=256) and `x_out` stays 0. Without the macro, the 5120 case gives `x_out`=0 with `valid`.
- **Remainder fault:** after reset, y=205 → `err` with `x_out`=0. A following y=40 → `x_out`=2, showing the history was untouched by the fault.
- **Negative fault:** after recovering 10 then 20 (y=200, 550), y=100 → `err` (r=−300). A following y=1000 → `x_out`=30.
- **Busy and reset:** `go` with y=200, a second `go` with y=550 at E5 (ignored), giving a single `valid` with `x_out`=10. Then `go` with y=400 and `rst` at E10 → no `valid`/`err`, `busy`=0 and `x_out`=0 the next cycle.
